// File: rtl/delay_calib_ctrl.sv
// delay_calib_ctrl: sweeps a delay-line tap select upward, waiting for the
// line to settle after every step, and records the first tap at which the
// sampled delayed-clock phase differs from the phase seen at tap 0.
// If no tap shows a change the sweep ends with fail_o set and the previous
// result kept.
// Optional build macro: DELAY_CALIB_MAJORITY_EN -- the sample phase spans
// three cycles and the 2-of-3 majority is used, filtering single-cycle glitches.
module delay_calib_ctrl #(
  parameter int NUM_STEPS       = 16,
  parameter int SETTLE_CYCLES   = 8,
  localparam int DELAY_SEL_WIDTH = $clog2(NUM_STEPS)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       sample_i,
  output logic [DELAY_SEL_WIDTH-1:0] delay_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       fail_o
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0]        SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [DELAY_SEL_WIDTH-1:0] TAP_LAST    = DELAY_SEL_WIDTH'(NUM_STEPS - 1);
  localparam logic [DELAY_SEL_WIDTH-1:0] TAP_ONE     = DELAY_SEL_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                     state_reg;
  logic [DELAY_SEL_WIDTH-1:0] tap_reg;
  logic [DELAY_SEL_WIDTH-1:0] result_reg;
  logic [SETTLE_W-1:0]        settle_cnt_reg;
  logic                       ref_reg;

  // Value of the delayed phase used for the decision, and whether the
  // current SAMPLE cycle is the one on which the decision is taken.
  logic sample_value;
  logic sample_last;

`ifdef DELAY_CALIB_MAJORITY_EN
  logic [1:0] sample_cnt_reg;
  logic [1:0] sample_hist_reg;

  assign sample_last  = (sample_cnt_reg == 2'd2);
  assign sample_value = (sample_hist_reg[0] & sample_hist_reg[1]) |
                        (sample_hist_reg[0] & sample_i) |
                        (sample_hist_reg[1] & sample_i);

  // Capture the first two of the three SAMPLE-cycle values; the third is live.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_cnt_reg  <= 2'd0;
      sample_hist_reg <= 2'b00;
    end else if (state_reg == SAMPLE) begin
      sample_cnt_reg                     <= sample_last ? 2'd0 : sample_cnt_reg + 2'd1;
      sample_hist_reg[sample_cnt_reg[0]] <= sample_i;
    end else begin
      sample_cnt_reg <= 2'd0;
    end
  end
`else
  assign sample_last  = 1'b1;
  assign sample_value = sample_i;
`endif

  // Calibration FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      tap_reg        <= '0;
      result_reg     <= '0;
      settle_cnt_reg <= '0;
      ref_reg        <= 1'b0;
      delay_o        <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      fail_o         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state_reg      <= SETTLE;
            tap_reg        <= '0;
            settle_cnt_reg <= '0;
            fail_o         <= 1'b0;
            busy_o         <= 1'b1;
            delay_o        <= '0;
          end
        end

        SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            settle_cnt_reg <= '0;
            state_reg      <= SAMPLE;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + SETTLE_W'(1);
          end
        end

        SAMPLE: begin
          if (sample_last) begin
            if (tap_reg == '0) begin
              // Tap 0 defines the reference phase.
              ref_reg   <= sample_value;
              tap_reg   <= TAP_ONE;
              delay_o   <= TAP_ONE;
              state_reg <= SETTLE;
            end else if (sample_value != ref_reg) begin
              result_reg <= tap_reg;
              delay_o    <= tap_reg;
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
              state_reg  <= DONE;
            end else if (tap_reg == TAP_LAST) begin
              // Ran out of taps: keep the old result, no wrap-around.
              fail_o    <= 1'b1;
              delay_o   <= result_reg;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              state_reg <= DONE;
            end else begin
              tap_reg   <= tap_reg + TAP_ONE;
              delay_o   <= tap_reg + TAP_ONE;
              state_reg <= SETTLE;
            end
          end
        end

        DONE: begin
          done_o    <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy_o    <= 1'b0;
          done_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/delay_calib_ctrl.md
DELAY_CALIB_CTRL -- requirements
Module: delay_calib_ctrl

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 16, number of delay-line taps; must be a power of two and at least 2.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8, cycles waited after each tap change before sampling; must be at least 1.
REQ-003 SHALL derive localparam DELAY_SEL_WIDTH = $clog2(NUM_STEPS).
REQ-004 SHALL have port clk_i, input, 1 bit: single clock, rising-edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start_i, input, 1 bit: start calibration; level-sampled in IDLE only.
REQ-007 SHALL have port sample_i, input, 1 bit: delayed-clock phase, already synchronised to clk_i by the caller.
REQ-008 SHALL have port delay_o, output, DELAY_SEL_WIDTH bits: tap select driving the delay line's delay input.
REQ-009 SHALL have port busy_o, output, 1 bit: high in SETTLE and SAMPLE.
REQ-010 SHALL have port done_o, output, 1 bit: one-cycle pulse at calibration end, whether it passed or failed.
REQ-011 SHALL have port fail_o, output, 1 bit: set when no edge was found; holds until the next start.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-013 IDLE with start_i=1 SHALL move to SETTLE on the next edge, with tap=0, settle counter=0 and fail_o=0.
REQ-014 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then move to SAMPLE.
REQ-015 SAMPLE SHALL last 1 cycle, or 3 cycles when the macro in REQ-027 is defined, and evaluate the sample value at its last cycle.
REQ-016 At tap 0, SAMPLE SHALL store the sample value as ref and continue at tap 1 in SETTLE.
REQ-017 At tap k>0, a sample value differing from ref SHALL store result=k and move to DONE.
REQ-018 At tap k>0, a sample value equal to ref SHALL continue at tap k+1 in SETTLE.
REQ-019 A matching sample at tap NUM_STEPS-1 SHALL set fail_o=1, leave result unchanged and move to DONE; the tap counter SHALL NOT wrap.
REQ-020 delay_o SHALL equal the tap counter in SETTLE and SAMPLE, and the result register in IDLE and DONE.
REQ-021 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-022 start_i SHALL be ignored outside IDLE; start_i held high SHALL restart calibration on the cycle after DONE.
REQ-023 Per-tap latency SHALL be SETTLE_CYCLES+1 cycles, or SETTLE_CYCLES+3 with the macro defined.

Reset
REQ-024 Reset SHALL put the FSM in IDLE and set delay_o=0, result=0, ref=0, busy_o=0, done_o=0, fail_o=0, and both counters to 0.
REQ-025 Reset asserted mid-calibration SHALL abort immediately with no done_o pulse; the result SHALL read 0 after release.
REQ-026 All state SHALL be reset asynchronously on rst_ni falling; release SHALL be synchronous to clk_i as provided externally.

Configuration
REQ-027 Defining DELAY_CALIB_MAJORITY_EN SHALL sample sample_i on 3 consecutive SAMPLE cycles and use the 2-of-3 majority as the sample value.
REQ-028 Without DELAY_CALIB_MAJORITY_EN, the sample value SHALL be sample_i on the single SAMPLE cycle and no majority logic SHALL be present.

Verification (NUM_STEPS=16, SETTLE_CYCLES=4, macro undefined unless stated)
REQ-029 Pulse start_i at cycle 0; sample_i=0 for taps 0-4 and 1 from tap 5 -> busy_o is high cycles 1-30, done_o pulses at cycle 31, delay_o=5, fail_o=0.
REQ-030 Hold sample_i=1 constantly, pulse start -> tap 15 is reached, done_o pulses at cycle 81, fail_o=1, and delay_o keeps its previous result (0 after reset).
REQ-031 Pulse start_i again while busy at tap 3 -> no restart, the sweep continues unchanged, and only one done_o pulse occurs.
REQ-032 Drop rst_ni at cycle 12 during calibration -> all outputs are 0 in the same cycle and no done_o pulse occurs; after release a start gives a normal sweep.
REQ-033 With the macro defined, toggle sample_i to 1 for one single cycle within the SAMPLE window at tap 2, with the true edge at tap 6 -> tap 2 is rejected, done_o gives delay_o=6, and per-tap latency is 7 cycles.
REQ-034 Hold start_i high continuously -> back-to-back calibrations occur with exactly one IDLE cycle between the done_o pulse and the next busy_o.
